// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: state encoding and request decode helper.
package mem_arb_pkg;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_FWAIT   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_DWAIT   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH   = ST_FETCH,
    S_FWAIT   = ST_FWAIT,
    S_DATA    = ST_DATA,
    S_DWAIT   = ST_DWAIT,
    S_RELEASE = ST_RELEASE
  } arb_state_t;

  function automatic logic dm_access(input logic cs, input logic rd, input logic wr);
    return cs & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Free-running 32-bit instruction and stall counters for the arbiter; wrap at 2^32.
// Both update one cycle after the event they count; synchronous reset clears them.
module mem_arb_perf (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_release,
  input  logic        i_stall,
  output logic [31:0] o_perf_instr,
  output logic [31:0] o_perf_stall
);

  logic [31:0] r_instr;
  logic [31:0] r_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_instr <= '0;
      r_stall <= '0;
    end else begin
      if (i_release) r_instr <= r_instr + 32'd1;
      if (i_stall)   r_stall <= r_stall + 32'd1;
    end
  end

  assign o_perf_instr = r_instr;
  assign o_perf_stall = r_stall;

endmodule

// File: rtl/mem_arbiter.sv
// Time-shares one single-port RAM between fetch and data ports: fetch, optional load/store, release.
// CPI with read latency L: 2+L (no data), 3+L (store), 3+2L (load). Perf counters under MEM_ARB_PERF_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr_imem,
  input  logic [31:0]       addr_dmem,
  input  logic [31:0]       wdata,
  input  logic              DM_CS,
  input  logic              DM_R,
  input  logic              DM_W,
  output logic [31:0]       inst,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       perf_instr,
  output logic [31:0]       perf_stall
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_inst;
  logic [31:0]      r_rdata;

  logic              w_store;
  logic              w_load;
  logic              w_stall;
  logic              w_re;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_unused_addr;

  // Store wins when both read and write are requested.
  assign w_store = DM_CS & DM_W;
  assign w_load  = DM_CS & DM_R & ~DM_W;
  assign w_stall = (r_state != S_RELEASE);

  // Word addressing: byte-offset bits and bits above the RAM are dropped, so addresses alias.
  assign w_unused_addr = ^{addr_imem[31:ADDR_W+2], addr_imem[1:0],
                           addr_dmem[31:ADDR_W+2], addr_dmem[1:0]};

  always_comb begin
    w_re    = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      S_FETCH: begin
        w_re   = ~reset;
        w_addr = addr_imem[ADDR_W+1:2];
      end
      S_DATA: begin
        if (w_store) begin
          w_we    = ~reset;
          w_addr  = addr_dmem[ADDR_W+1:2];
          w_wdata = wdata;
        end else if (w_load) begin
          w_re   = ~reset;
          w_addr = addr_dmem[ADDR_W+1:2];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_inst  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_cnt   <= CNT_LOAD;
          r_state <= S_FWAIT;
        end
        S_FWAIT: begin
          if (r_cnt == '0) begin
            r_inst  <= mem_rdata;
            r_state <= dm_access(DM_CS, DM_R, DM_W) ? S_DATA : S_RELEASE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_load) begin
            r_cnt   <= CNT_LOAD;
            r_state <= S_DWAIT;
          end else begin
            r_state <= S_RELEASE;
          end
        end
        S_DWAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= mem_rdata;
            r_state <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RELEASE: r_state <= S_FETCH;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  assign inst      = r_inst;
  assign rdata     = r_rdata;
  assign stall     = w_stall;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;
  assign mem_re    = w_re;
  assign mem_we    = w_we;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_release    (r_state == S_RELEASE),
    .i_stall      (w_stall),
    .o_perf_instr (perf_instr),
    .o_perf_stall (perf_stall)
  );
`else
  assign perf_instr = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiters (read latency 1 and 3) each on its own RAM model, checked against per-instruction predictions.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int NW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic [31:0]   addr_imem [2];
  logic [31:0]   addr_dmem [2];
  logic [31:0]   wdata     [2];
  logic          dm_cs     [2];
  logic          dm_r      [2];
  logic          dm_w      [2];
  logic [31:0]   inst      [2];
  logic [31:0]   rdata     [2];
  logic          stall     [2];
  logic [AW-1:0] mem_addr  [2];
  logic [31:0]   mem_wdata [2];
  logic          mem_re    [2];
  logic          mem_we    [2];
  logic [31:0]   perf_i    [2];
  logic [31:0]   perf_s    [2];

  logic [31:0] mem  [2][NW];
  logic [31:0] rp   [2][3];
  logic        mem_init;

  logic [31:0] gmem   [2][NW];
  logic [31:0] exp_rd [2];
  bit          first  [2];

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.ADDR_W(AW), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(rst[0]), .addr_imem(addr_imem[0]), .addr_dmem(addr_dmem[0]),
    .wdata(wdata[0]), .DM_CS(dm_cs[0]), .DM_R(dm_r[0]), .DM_W(dm_w[0]),
    .inst(inst[0]), .rdata(rdata[0]), .stall(stall[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_re(mem_re[0]), .mem_we(mem_we[0]),
    .mem_rdata(rp[0][0]), .perf_instr(perf_i[0]), .perf_stall(perf_s[0])
  );

  mem_arbiter #(.ADDR_W(AW), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(rst[1]), .addr_imem(addr_imem[1]), .addr_dmem(addr_dmem[1]),
    .wdata(wdata[1]), .DM_CS(dm_cs[1]), .DM_R(dm_r[1]), .DM_W(dm_w[1]),
    .inst(inst[1]), .rdata(rdata[1]), .stall(stall[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_re(mem_re[1]), .mem_we(mem_we[1]),
    .mem_rdata(rp[1][2]), .perf_instr(perf_i[1]), .perf_stall(perf_s[1])
  );

  function automatic logic [31:0] init_word(input int l, input int a);
    if (a == 0) return 32'h20080005;
    if (a == 4) return 32'hCAFEF00D;
    return 32'(a) * 32'h9E3779B1 + 32'(l);
  endfunction

  // RAM model: read data appears RD_LAT cycles after the strobe; junk otherwise so mistimed captures show.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (mem_init) begin
        for (int a = 0; a < NW; a++) mem[l][a] <= init_word(l, a);
      end else if (mem_we[l]) begin
        mem[l][mem_addr[l]] <= mem_wdata[l];
      end
      rp[l][0] <= mem_re[l] ? mem[l][mem_addr[l]] : 32'hBAD0BAD0;
      rp[l][1] <= rp[l][0];
      rp[l][2] <= rp[l][1];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input int ln, input logic [31:0] pc, input logic cs, input logic r,
                       input logic w, input logic [31:0] da, input logic [31:0] wd);
    addr_imem[ln] = pc;
    dm_cs[ln]     = cs;
    dm_r[ln]      = r;
    dm_w[ln]      = w;
    addr_dmem[ln] = da;
    wdata[ln]     = wd;
  endtask

  task automatic do_reset(input int ln, input int ncyc);
    rst[ln] = 1'b1;
    repeat (ncyc) @(negedge clk);
    check_val("rst_stall", stall[ln], 1);
    check_val("rst_inst", inst[ln], 0);
    check_val("rst_rdata", rdata[ln], 0);
    check_val("rst_re", mem_re[ln], 0);
    check_val("rst_we", mem_we[ln], 0);
    check_val("rst_perf_instr", perf_i[ln], 0);
    check_val("rst_perf_stall", perf_s[ln], 0);
    exp_rd[ln] = '0;
    rst[ln]    = 1'b0;
    first[ln]  = 1'b1;
  endtask

  // One instruction: predict cycles, strobes and results from the access kind, then watch the DUT.
  task automatic run_instr(input int ln, input logic [31:0] pc, input logic cs, input logic r,
                           input logic w, input logic [31:0] da, input logic [31:0] wd);
    logic [AW-1:0] pw;
    logic [AW-1:0] dw;
    logic [31:0]   exp_inst;
    bit   is_st, is_ld, done, pre;
    int   lat, exp_cyc, cyc, nre, nwe;
    pw    = pc[AW+1:2];
    dw    = da[AW+1:2];
    is_st = cs && w;
    is_ld = cs && r && !w;
    lat   = (ln == 0) ? 1 : 3;
    exp_cyc  = is_st ? 3 + lat : (is_ld ? 3 + 2 * lat : 2 + lat);
    exp_inst = gmem[ln][pw];
    if (is_ld) exp_rd[ln] = gmem[ln][dw];
    if (is_st) gmem[ln][dw] = wd;
    drive(ln, pc, cs, r, w, da, wd);
    cyc = 0; nre = 0; nwe = 0; done = 0;
    pre = first[ln];
    first[ln] = 1'b0;
    if (pre) #1;
    else @(negedge clk);
    while (1) begin
      cyc++;
      check_val("strobe_excl", 32'(mem_re[ln] & mem_we[ln]), 0);
      if (cyc == 1) begin
        check_val("fetch_re", mem_re[ln], 1);
        check_val("fetch_addr", 32'(mem_addr[ln]), 32'(pw));
      end
      if (mem_we[ln]) begin
        nwe++;
        check_val("st_addr", 32'(mem_addr[ln]), 32'(dw));
        check_val("st_wdata", mem_wdata[ln], wd);
      end
      if (mem_re[ln]) begin
        nre++;
        if (cyc > 1) check_val("ld_addr", 32'(mem_addr[ln]), 32'(dw));
      end
      if (!stall[ln]) done = 1;
      if (done || cyc >= 40) break;
      @(negedge clk);
    end
    check_val("timeout", 32'(done), 1);
    check_val("cycles", 32'(cyc), 32'(exp_cyc));
    check_val("num_reads", 32'(nre), 32'(1 + int'(is_ld)));
    check_val("num_writes", 32'(nwe), 32'(is_st));
    check_val("inst", inst[ln], exp_inst);
    check_val("rdata", rdata[ln], exp_rd[ln]);
    check_val("idle_addr", 32'(mem_addr[ln]), 0);
    check_val("idle_wdata", mem_wdata[ln], 0);
  endtask

  task automatic reset_pulse(input int ln);
    logic [31:0]   da, wd;
    logic [AW-1:0] dw;
    int n;
    da = $urandom;
    wd = $urandom;
    dw = da[AW+1:2];
    drive(ln, $urandom, 1'b1, 1'b0, 1'b1, da, wd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_we[ln] && n < 20);
    check_val("rstp_reach_data", mem_we[ln], 1);
    rst[ln] = 1'b1;
    #1;
    check_val("rstp_we_gated", mem_we[ln], 0);
    @(negedge clk);
    check_val("rstp_stall", stall[ln], 1);
    check_val("rstp_inst", inst[ln], 0);
    check_val("rstp_perf_instr", perf_i[ln], 0);
    check_val("rstp_mem_kept", mem[ln][dw], gmem[ln][dw]);
    exp_rd[ln] = '0;
    rst[ln]    = 1'b0;
    first[ln]  = 1'b1;
  endtask

  task automatic lane_run(input int ln);
    do_reset(ln, 3);
    for (int i = 0; i < 3; i++) run_instr(ln, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    run_instr(ln, 32'h0, 1, 1, 0, 32'h10, 32'h0);
    run_instr(ln, 32'h0, 0, 1, 1, 32'h10, 32'h0);
    run_instr(ln, 32'h0, 1, 0, 1, 32'h10, 32'hDEADBEEF);
    run_instr(ln, 32'h4, 1, 1, 1, 32'h24, 32'h12345678);
    run_instr(ln, 32'h1000_0104, 1, 1, 0, 32'hFFFF_FF11, 32'h0);
    for (int i = 0; i < 100; i++)
      run_instr(ln, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom, $urandom);
    reset_pulse(ln);
    for (int i = 0; i < 4; i++)
      run_instr(ln, $urandom, 1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    do_reset(ln, 2);
    for (int i = 0; i < 10; i++) run_instr(ln, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    check_val("perf_instr_10", perf_i[ln], (ln == 0) ? 32'd10 : 32'd10);
    check_val("perf_stall", perf_s[ln], (ln == 0) ? 32'd20 : 32'd40);
`else
    check_val("perf_instr_off", perf_i[ln], 0);
    check_val("perf_stall_off", perf_s[ln], 0);
`endif
    rst[ln] = 1'b1;
    for (int a = 0; a < NW; a++) check_val("mem_final", mem[ln][a], gmem[ln][a]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1;
      drive(l, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      exp_rd[l] = '0;
      first[l]  = 1'b0;
      for (int a = 0; a < NW; a++) gmem[l][a] = init_word(l, a);
    end
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    lane_run(0);
    lane_run(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
